vga_pixel_sink: RTL and testbench
=================================

VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: pixel-write buffer depth, power of two, 2..16.
REQ-002 Parameter H_RES, default 160: visible columns.
REQ-003 Parameter V_RES, default 120: visible rows.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 plot  in  1  pixel-write strobe from the drawing FSM; one pixel per high cycle; no backpressure.
REQ-007 x  in  9  pixel column.
REQ-008 y  in  9  pixel row.
REQ-009 colour  in  3  pixel colour.
REQ-010 scan_req  in  1  display scan-out read request; highest priority.
REQ-011 scan_addr  in  15  framebuffer address to read.
REQ-012 scan_data  out  3  read colour; valid when scan_valid=1.
REQ-013 scan_valid  out  1  registered; high exactly one cycle after each scan_req cycle.
REQ-014 ram_addr  out  15  single-port framebuffer address.
REQ-015 ram_we  out  1  framebuffer write enable.
REQ-016 ram_wdata  out  3  framebuffer write data.
REQ-017 ram_rdata  in  3  framebuffer read data; synchronous RAM, 1-cycle read latency.
REQ-018 ready  out  1  high once the power-on clear is complete.
REQ-019 busy  out  1  FIFO full.
REQ-020 overflow  out  1  sticky: a valid plot was dropped because the FIFO was full.

Function
REQ-021 FSM states: CLEAR (write colour 0 to addresses 0..H_RES*V_RES-1) and RUN (drain the FIFO); CLEAR->RUN after address 19199 is written; RUN holds until reset.
REQ-022 Port arbitration per cycle: scan_req=1 -> ram_addr=scan_addr, ram_we=0; otherwise CLEAR write, or RUN FIFO pop-and-write if non-empty; otherwise ram_we=0.
REQ-023 A scan_req stalls the CLEAR counter and the FIFO drain for that cycle; no clear address is skipped or repeated.
REQ-024 scan_data = ram_rdata, passed through combinationally; scan_valid = scan_req delayed by one register.
REQ-025 Clipping: a plot with x>=H_RES or y>=V_RES is discarded, never pushed, and never sets overflow.
REQ-026 Address = y*H_RES + x, computed as (y<<7)+(y<<5)+x for H_RES=160, 15 bits wide; maximum 19199.
REQ-027 A valid plot pushes {address, colour} when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-028 A valid plot with the FIFO full and no same-cycle pop is dropped and sets overflow.
REQ-029 Plots arriving during CLEAR are buffered under the same rules; draining starts on the first RUN cycle.
REQ-030 Write latency: in RUN, with the FIFO empty and no scan_req, a plot at cycle N produces ram_we=1 at cycle N+1.
REQ-031 FIFO order is strictly first-in first-out; the same address written twice keeps the last colour.
REQ-032 ready=1 in RUN only; busy is asserted combinationally from the FIFO count equal to FIFO_DEPTH.

Reset
REQ-033 reset low, asynchronously: state=CLEAR, clear counter=0, FIFO empty, overflow=0, scan_valid=0, ready=0, busy=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-034 Reset asserted mid-CLEAR or mid-drain discards buffered pixels; the clear restarts at address 0 on release.

Configuration
REQ-035 When VGA_SINK_CLIPCNT_EN is defined, output clip_count (8 bits) increments on every clipped plot, saturates at 255, and is 0 on reset.
REQ-036 When VGA_SINK_CLIPCNT_EN is not defined, neither the clip_count port nor its counter exists.

Structure
REQ-037 Package vga_pkg holds H_RES/V_RES defaults, FB_AW=15, colour_t (3-bit), the pixel record {addr, colour}, and the sink state enum.
REQ-038 Sub-module vga_pixel_fifo implements the synchronous FIFO (push, pop, full, empty, count); all other logic stays in vga_pixel_sink.

Verification
REQ-039 Reset release, no scan_req -> 19200 consecutive writes of colour 0 to addresses 0..19199; ready=1 on the cycle after the last write.
REQ-040 RUN, plot (x=159, y=119, colour=5) -> next cycle ram_we=1, ram_addr=19199, ram_wdata=5.
REQ-041 Plots (160,0) and (0,120) -> no write, overflow=0; with the macro defined, clip_count=2.
REQ-042 RUN, scan_req held high for 10 cycles while 6 plots arrive, FIFO_DEPTH=4 -> 4 buffered, overflow=1, busy=1; after release, 4 writes in arrival order.
REQ-043 scan_req with scan_addr=320 after plot (0,2,colour 3) was written -> scan_valid=1 one cycle later with scan_data=3.
REQ-044 Reset pulse at clear address 5000 -> FIFO emptied, ready=0, clear restarts at 0 and completes 19200 writes.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types for the VGA pixel sink: framebuffer geometry,
// the buffered pixel record and the sink state encoding.
package vga_pkg;

   localparam int H_RES_DEF = 160;
   localparam int V_RES_DEF = 120;
   localparam int FB_AW     = 15;

   typedef logic [2:0] colour_t;

   typedef struct packed {
      logic [FB_AW-1:0] addr;
      colour_t          colour;
   } pixel_t;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } sink_state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous FIFO of pending pixel writes; DEPTH must be a
// power of two so the pointers wrap naturally.
module vga_pixel_fifo
   import vga_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  pixel_t                 din,
   output pixel_t                 dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   pixel_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;

endmodule

// File: rtl/vga_pixel_sink.sv
// Framebuffer port arbiter: power-on clear, buffered plots, scan reads.
// Define VGA_SINK_CLIPCNT_EN to add the saturating clip_count output.
module vga_pixel_sink
   import vga_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int H_RES      = H_RES_DEF,
   parameter int V_RES      = V_RES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        plot,
   input  logic [8:0]  x,
   input  logic [8:0]  y,
   input  logic [2:0]  colour,
   input  logic        scan_req,
   input  logic [14:0] scan_addr,
   output logic [2:0]  scan_data,
   output logic        scan_valid,
   output logic [14:0] ram_addr,
   output logic        ram_we,
   output logic [2:0]  ram_wdata,
   input  logic [2:0]  ram_rdata,
   output logic        ready,
   output logic        busy,
   output logic        overflow
`ifdef VGA_SINK_CLIPCNT_EN
   ,
   output logic [7:0]  clip_count
`endif
);

   localparam logic [8:0]       X_LIM = 9'(H_RES);
   localparam logic [8:0]       Y_LIM = 9'(V_RES);
   localparam logic [FB_AW-1:0] LAST  = FB_AW'(H_RES * V_RES - 1);
   localparam int               CW    = $clog2(FIFO_DEPTH) + 1;

   sink_state_t      state;
   logic             armed;
   logic [FB_AW-1:0] clr_addr;
   logic             clipped;
   logic             hit;
   logic             scan_go;
   logic             clr_we;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;
   pixel_t           pix_in;
   pixel_t           pix_out;

   assign clipped       = (x >= X_LIM) || (y >= Y_LIM);
   assign hit           = plot && !clipped;
   assign pix_in.addr   = FB_AW'(y) * FB_AW'(H_RES) + FB_AW'(x);
   assign pix_in.colour = colour;

   // armed keeps the RAM port idle while reset is held
   assign scan_go = scan_req && armed;
   assign clr_we  = armed && (state == ST_CLEAR) && !scan_req;
   assign pop     = (state == ST_RUN) && !scan_req && !empty;
   assign push    = hit && (!full || pop);

   vga_pixel_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pix_in),
      .dout  (pix_out),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_CLEAR;
         armed      <= 1'b0;
         clr_addr   <= '0;
         overflow   <= 1'b0;
         scan_valid <= 1'b0;
      end else begin
         armed      <= 1'b1;
         scan_valid <= scan_go;
         if (hit && full && !pop) overflow <= 1'b1;
         if (clr_we) begin
            if (clr_addr == LAST) state <= ST_RUN;
            clr_addr <= clr_addr + 1'b1;
         end
      end
   end

   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (scan_go) begin
         ram_addr = scan_addr;
      end else if (clr_we) begin
         ram_addr = clr_addr;
         ram_we   = 1'b1;
      end else if (pop) begin
         ram_addr  = pix_out.addr;
         ram_we    = 1'b1;
         ram_wdata = pix_out.colour;
      end
   end

   assign scan_data = ram_rdata;
   assign ready     = state == ST_RUN;
   assign busy      = count == CW'(FIFO_DEPTH);

`ifdef VGA_SINK_CLIPCNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clip_count <= '0;
      end else if (plot && clipped && clip_count != 8'hFF) begin
         clip_count <= clip_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Testbench for vga_pixel_sink with a behavioural framebuffer RAM
// and a queue-based reference model of the pending pixel writes.
module tb_vga_pixel_sink;

   localparam int DEPTH = 4;
   localparam int NPIX  = 19200;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        plot = 1'b0;
   logic [8:0]  x = '0;
   logic [8:0]  y = '0;
   logic [2:0]  colour = '0;
   logic        scan_req = 1'b0;
   logic [14:0] scan_addr = '0;
   logic [2:0]  scan_data;
   logic        scan_valid;
   logic [14:0] ram_addr;
   logic        ram_we;
   logic [2:0]  ram_wdata;
   logic [2:0]  ram_rdata;
   logic        ready;
   logic        busy;
   logic        overflow;
`ifdef VGA_SINK_CLIPCNT_EN
   logic [7:0]  clip_count;
`endif

   int tests = 0;
   int fails = 0;

   logic [2:0] ram [0:32767];
   bit   [2:0] exp_fb [0:NPIX-1];

   vga_pixel_sink #(
      .FIFO_DEPTH (DEPTH),
      .H_RES      (160),
      .V_RES      (120)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .plot       (plot),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .scan_req   (scan_req),
      .scan_addr  (scan_addr),
      .scan_data  (scan_data),
      .scan_valid (scan_valid),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .ready      (ready),
      .busy       (busy),
      .overflow   (overflow)
`ifdef VGA_SINK_CLIPCNT_EN
      ,
      .clip_count (clip_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   task automatic clear_walk(input int n, input int pstart, input int pcnt,
                             output int bad, output int first_bad);
      bit seen;
      seen = 0;
      bad = 0;
      first_bad = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ram_we === 1'b1) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!seen) begin
         bad = n;
         first_bad = 0;
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
            if (i >= pstart && i < pstart + pcnt) begin
               plot = 1;
               x = 9'((i - pstart) * 10);
               y = 9'(i - pstart + 1);
               colour = 3'(i - pstart + 1);
            end else begin
               plot = 0;
            end
            @(negedge clk);
         end
         if (ram_we !== 1'b1 || ram_addr !== 15'(i) ||
             ram_wdata !== 3'd0 || ready !== 1'b0) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (ram_we !== 1'b0 || ram_addr !== 15'd0 || ram_wdata !== 3'd0) begin
         fails++;
         $display("FAIL reset_ram got we=%0d addr=%0d data=%0d exp 0 0 0",
                  ram_we, ram_addr, ram_wdata);
      end
      tests++;
      if ({ready, busy, overflow, scan_valid} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags got rdy/busy/ovf/sv=%b exp 0000",
                  {ready, busy, overflow, scan_valid});
      end
`ifdef VGA_SINK_CLIPCNT_EN
      tests++;
      if (clip_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_clip got %0d exp 0", clip_count);
      end
`endif
   endtask

   task automatic test_clear();
      int bad;
      int fb;
      int ea;
      @(posedge clk);
      #1;
      reset = 1;
      clear_walk(NPIX, 1, 2, bad, fb);
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL clear_seq got bad=%0d first=%0d exp bad=0", bad, fb);
      end
      for (int j = 0; j < 2; j++) begin
         @(posedge clk);
         #1;
         plot = 0;
         @(negedge clk);
         ea = (j + 1) * 160 + 10 * j;
         tests++;
         if (ready !== 1'b1 || ram_we !== 1'b1 ||
             ram_addr !== 15'(ea) || ram_wdata !== 3'(j + 1)) begin
            fails++;
            $display("FAIL clear_drain got rdy=%0d we=%0d addr=%0d data=%0d exp 1 1 %0d %0d",
                     ready, ram_we, ram_addr, ram_wdata, ea, j + 1);
         end
         exp_fb[ea] = 3'(j + 1);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (ram_we !== 1'b0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL clear_idle got we=%0d rdy=%0d exp 0 1", ram_we, ready);
      end
   endtask

   task automatic test_write_latency();
      @(posedge clk);
      #1;
      plot = 1; x = 159; y = 119; colour = 5;
      @(negedge clk);
      tests++;
      if (ram_we !== 1'b0) begin
         fails++;
         $display("FAIL lat_early got we=%0d exp 0", ram_we);
      end
      @(posedge clk);
      #1;
      plot = 0;
      @(negedge clk);
      tests++;
      if (ram_we !== 1'b1 || ram_addr !== 15'd19199 || ram_wdata !== 3'd5) begin
         fails++;
         $display("FAIL lat_write got we=%0d addr=%0d data=%0d exp 1 19199 5",
                  ram_we, ram_addr, ram_wdata);
      end
      exp_fb[19199] = 5;
   endtask

   task automatic test_clip();
      int bad;
      bad = 0;
      @(posedge clk);
      #1;
      plot = 1; x = 160; y = 0; colour = 7;
      @(negedge clk);
      if (ram_we !== 1'b0) bad++;
      @(posedge clk);
      #1;
      x = 0; y = 120;
      @(negedge clk);
      if (ram_we !== 1'b0) bad++;
      @(posedge clk);
      #1;
      plot = 0;
      @(negedge clk);
      if (ram_we !== 1'b0) bad++;
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL clip_write got %0d write cycles exp 0", bad);
      end
      tests++;
      if (overflow !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL clip_flags got ovf=%0d busy=%0d exp 0 0", overflow, busy);
      end
`ifdef VGA_SINK_CLIPCNT_EN
      tests++;
      if (clip_count !== 8'd2) begin
         fails++;
         $display("FAIL clip_count got %0d exp 2", clip_count);
      end
`endif
   endtask

   task automatic test_scan_read();
      @(posedge clk);
      #1;
      plot = 1; x = 0; y = 2; colour = 3;
      @(negedge clk);
      @(posedge clk);
      #1;
      plot = 0;
      @(negedge clk);
      tests++;
      if (ram_we !== 1'b1 || ram_addr !== 15'd320 || ram_wdata !== 3'd3) begin
         fails++;
         $display("FAIL scan_pre got we=%0d addr=%0d data=%0d exp 1 320 3",
                  ram_we, ram_addr, ram_wdata);
      end
      exp_fb[320] = 3;
      @(posedge clk);
      #1;
      scan_req = 1; scan_addr = 320;
      @(negedge clk);
      tests++;
      if (ram_addr !== 15'd320 || ram_we !== 1'b0 || scan_valid !== 1'b0) begin
         fails++;
         $display("FAIL scan_req got addr=%0d we=%0d sv=%0d exp 320 0 0",
                  ram_addr, ram_we, scan_valid);
      end
      @(posedge clk);
      #1;
      scan_req = 0;
      @(negedge clk);
      tests++;
      if (scan_valid !== 1'b1 || scan_data !== 3'd3) begin
         fails++;
         $display("FAIL scan_data got sv=%0d data=%0d exp 1 3", scan_valid, scan_data);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (scan_valid !== 1'b0) begin
         fails++;
         $display("FAIL scan_once got sv=%0d exp 0", scan_valid);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      int ea;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         scan_req = 1;
         scan_addr = 15'(c * 7);
         plot = (c < 6);
         x = 9'(30 + c); y = 50; colour = 3'(c + 1);
         @(negedge clk);
         if (ram_we !== 1'b0 || ram_addr !== scan_addr) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL stall_port got %0d bad cycles exp 0", bad);
      end
      tests++;
      if (overflow !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL stall_flags got ovf=%0d busy=%0d exp 1 1", overflow, busy);
      end
      for (int j = 0; j < 4; j++) begin
         @(posedge clk);
         #1;
         scan_req = 0; plot = 0;
         @(negedge clk);
         ea = 50 * 160 + 30 + j;
         tests++;
         if (ram_we !== 1'b1 || ram_addr !== 15'(ea) || ram_wdata !== 3'(j + 1)) begin
            fails++;
            $display("FAIL stall_drain%0d got we=%0d addr=%0d data=%0d exp 1 %0d %0d",
                     j, ram_we, ram_addr, ram_wdata, ea, j + 1);
         end
         exp_fb[ea] = 3'(j + 1);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (ram_we !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL stall_end got we=%0d busy=%0d exp 0 0", ram_we, busy);
      end
   endtask

   task automatic test_reset_mid_clear();
      int bad;
      int fb;
      @(posedge clk);
      #1;
      reset = 0;
      @(posedge clk);
      #1;
      reset = 1;
      clear_walk(5000, 1, 5, bad, fb);
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL mid_clear_seq got bad=%0d first=%0d exp bad=0", bad, fb);
      end
      tests++;
      if (busy !== 1'b1 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL mid_clear_fill got busy=%0d ovf=%0d exp 1 1", busy, overflow);
      end
      reset = 0;
      #1;
      tests++;
      if ({ready, busy, overflow, scan_valid, ram_we} !== 5'b0 ||
          ram_addr !== 15'd0 || ram_wdata !== 3'd0) begin
         fails++;
         $display("FAIL mid_reset got rdy/busy/ovf/sv/we=%b addr=%0d data=%0d exp 00000 0 0",
                  {ready, busy, overflow, scan_valid, ram_we}, ram_addr, ram_wdata);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      clear_walk(NPIX, 0, 0, bad, fb);
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL reclear_seq got bad=%0d first=%0d exp bad=0", bad, fb);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (ready !== 1'b1 || ram_we !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reclear_end got rdy=%0d we=%0d busy=%0d exp 1 0 0",
                  ready, ram_we, busy);
      end
      for (int i = 0; i < NPIX; i++) exp_fb[i] = 0;
   endtask

   task automatic test_random();
      int q[$];
      bit m_ovf;
      bit prev_scan;
      int prev_addr;
      bit do_pop;
      int sz;
      int ea;
`ifdef VGA_SINK_CLIPCNT_EN
      int m_clip;
      m_clip = 0;
`endif
      m_ovf = 0;
      prev_scan = 0;
      prev_addr = 0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         #1;
         if (c < 580) begin
            scan_req = ($urandom % 10) < 3;
            scan_addr = 15'($urandom % NPIX);
            plot = ($urandom % 10) < 6;
            x = 9'($urandom % 171);
            y = 9'($urandom % 126);
            colour = 3'($urandom % 8);
         end else begin
            scan_req = 0;
            plot = 0;
         end
         @(negedge clk);
         tests++;
         if (scan_valid !== prev_scan) begin
            fails++;
            $display("FAIL rnd_sv c=%0d got %0d exp %0d", c, scan_valid, prev_scan);
         end
         if (prev_scan) begin
            tests++;
            if (scan_data !== exp_fb[prev_addr]) begin
               fails++;
               $display("FAIL rnd_read c=%0d addr=%0d got %0d exp %0d",
                        c, prev_addr, scan_data, exp_fb[prev_addr]);
            end
         end
         tests++;
         if (busy !== (q.size() == DEPTH) || overflow !== m_ovf) begin
            fails++;
            $display("FAIL rnd_flags c=%0d got busy=%0d ovf=%0d exp %0d %0d",
                     c, busy, overflow, q.size() == DEPTH, m_ovf);
         end
`ifdef VGA_SINK_CLIPCNT_EN
         tests++;
         if (clip_count !== 8'(m_clip)) begin
            fails++;
            $display("FAIL rnd_clip c=%0d got %0d exp %0d", c, clip_count, m_clip);
         end
`endif
         do_pop = !scan_req && q.size() > 0;
         tests++;
         if (do_pop) begin
            if (ram_we !== 1'b1 || ram_addr !== 15'(q[0] >> 3) ||
                ram_wdata !== 3'(q[0] & 7)) begin
               fails++;
               $display("FAIL rnd_write c=%0d got we=%0d addr=%0d data=%0d exp 1 %0d %0d",
                        c, ram_we, ram_addr, ram_wdata, q[0] >> 3, q[0] & 7);
            end
         end else if (ram_we !== 1'b0 || (scan_req && ram_addr !== scan_addr)) begin
            fails++;
            $display("FAIL rnd_idle c=%0d got we=%0d addr=%0d exp 0 %0d",
                     c, ram_we, ram_addr, scan_addr);
         end
         sz = q.size();
         if (do_pop) begin
            exp_fb[q[0] >> 3] = 3'(q[0] & 7);
            void'(q.pop_front());
         end
         if (plot) begin
            if (x < 160 && y < 120) begin
               ea = int'(y) * 160 + int'(x);
               if (sz < DEPTH || do_pop) q.push_back(ea * 8 + int'(colour));
               else m_ovf = 1;
            end else begin
`ifdef VGA_SINK_CLIPCNT_EN
               if (m_clip < 255) m_clip++;
`endif
            end
         end
         prev_scan = scan_req;
         prev_addr = int'(scan_addr);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_write_latency();
      test_clip();
      test_scan_read();
      test_back_to_back();
      test_reset_mid_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL watchdog time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

endmodule
